// File: rtl/bf16_norm_sched.sv
// bf16_norm_sched: round-robin shared bf16 normalizer (lzc, shift, exp adjust) between adder (0) and multiplier (1)
module bf16_norm_sched #(
  parameter int W = 16,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [W-1:0] req0_mant_i,
  input  logic [E-1:0] req0_exp_i,
  input  logic         req0_sign_i,
  input  logic [W-1:0] req1_mant_i,
  input  logic [E-1:0] req1_exp_i,
  input  logic         req1_sign_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_mant_o,
  output logic [E-1:0] out_exp_o,
  output logic         out_sign_o,
  output logic         out_src_o,
  output logic         out_uf_o
);
  localparam int C = $clog2(W + 1);
  logic         s1_v, s2_v, rr, s1_sign, s1_src;
  logic [W-1:0] s1_mant;
  logic [E-1:0] s1_exp;
  logic [1:0]   grant;
  logic         s1_adv, s2_adv, acc, zero, flush;
  logic [C-1:0] z;
  assign s2_adv = ~s2_v | out_ready_i;
  assign s1_adv = ~s1_v | s2_adv;
  assign grant[0] = req_valid_i[0] & (~req_valid_i[1] | ~rr);
  assign grant[1] = req_valid_i[1] & (~req_valid_i[0] | rr);
  assign req_ready_o = grant & {2{s1_adv}};
  assign acc = |req_ready_o;
  assign out_valid_o = s2_v;
  always_comb begin
    z = C'(W);
    for (int i = 0; i < W; i++)
      if (s1_mant[i]) z = C'(W - 1 - i);
  end
  assign zero = s1_mant == '0;
  assign flush = ~zero & (32'(s1_exp) <= 32'(z));
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      rr         <= 1'b0;
      s1_mant    <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_src     <= 1'b0;
      out_mant_o <= '0;
      out_exp_o  <= '0;
      out_sign_o <= 1'b0;
      out_src_o  <= 1'b0;
      out_uf_o   <= 1'b0;
    end else begin
      if (acc) begin
        rr      <= req_ready_o[0];
        s1_v    <= 1'b1;
        s1_mant <= req_ready_o[1] ? req1_mant_i : req0_mant_i;
        s1_exp  <= req_ready_o[1] ? req1_exp_i : req0_exp_i;
        s1_sign <= req_ready_o[1] ? req1_sign_i : req0_sign_i;
        s1_src  <= req_ready_o[1];
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_mant_o <= (zero | flush) ? '0 : s1_mant << z;
          out_exp_o  <= (zero | flush) ? '0 : s1_exp - E'(z);
          out_uf_o   <= flush;
          out_sign_o <= s1_sign;
          out_src_o  <= s1_src;
        end
      end
    end
  end
endmodule

// File: tb/tb_bf16_norm_sched.sv
// tb_bf16_norm_sched: randomized self-checking bench for bf16_norm_sched against a queue-based reference model
module tb_bf16_norm_sched;
  logic        clk = 0, rst = 1;
  logic [1:0]  req_valid_i = 0, req_ready_o;
  logic [15:0] req0_mant_i = 0, req1_mant_i = 0, out_mant_o;
  logic [7:0]  req0_exp_i = 0, req1_exp_i = 0, out_exp_o;
  logic        req0_sign_i = 0, req1_sign_i = 0;
  logic        out_valid_o, out_ready_i = 1, out_sign_o, out_src_o, out_uf_o;
  int          n_tests = 0, n_fail = 0, cyc = 0;
  typedef struct {logic [15:0] m; logic [7:0] e; logic s, src, uf; int t;} res_t;
  res_t q[$];
  bit   rr_m = 0;
  bf16_norm_sched dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_mant_i(req0_mant_i), .req0_exp_i(req0_exp_i), .req0_sign_i(req0_sign_i),
    .req1_mant_i(req1_mant_i), .req1_exp_i(req1_exp_i), .req1_sign_i(req1_sign_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_mant_o(out_mant_o),
    .out_exp_o(out_exp_o), .out_sign_o(out_sign_o), .out_src_o(out_src_o), .out_uf_o(out_uf_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic res_t model(input logic [15:0] m, input logic [7:0] e, input logic s, input logic src, input int t);
    res_t r;
    int z, mm;
    r.s = s; r.src = src; r.t = t; r.m = 0; r.e = 0; r.uf = 0;
    z = 0;
    mm = int'(m);
    if (mm != 0) begin
      while (mm < 32768) begin
        mm = mm * 2;
        z++;
      end
      if (int'(e) <= z) r.uf = 1;
      else begin
        r.m = mm[15:0];
        r.e = 8'(int'(e) - z);
      end
    end
    return r;
  endfunction
  always @(negedge clk) begin
    logic [1:0] win, exp_rdy;
    if (rst) begin
      q.delete();
      rr_m = 0;
    end else begin
      win = (req_valid_i == 2'b11) ? (rr_m ? 2'b10 : 2'b01) : req_valid_i;
      exp_rdy = (q.size() < 2 || out_ready_i) ? win : 2'b00;
      chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
      if (q.size() > 0) chk("out_valid", 32'(out_valid_o), 32'(q[0].t + 1 <= cyc));
      else chk("out_valid_idle", 32'(out_valid_o), 0);
      if (out_valid_o && q.size() > 0) begin
        chk("mant", 32'(out_mant_o), 32'(q[0].m));
        chk("exp", 32'(out_exp_o), 32'(q[0].e));
        chk("sign", 32'(out_sign_o), 32'(q[0].s));
        chk("src", 32'(out_src_o), 32'(q[0].src));
        chk("uf", 32'(out_uf_o), 32'(q[0].uf));
        if (out_ready_i) void'(q.pop_front());
      end
      if (exp_rdy[0]) begin
        q.push_back(model(req0_mant_i, req0_exp_i, req0_sign_i, 1'b0, cyc + 1));
        rr_m = 1;
      end else if (exp_rdy[1]) begin
        q.push_back(model(req1_mant_i, req1_exp_i, req1_sign_i, 1'b1, cyc + 1));
        rr_m = 0;
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic [15:0] m, input logic [7:0] e, input logic s);
    req0_mant_i = m; req0_exp_i = e; req0_sign_i = s;
  endtask
  task automatic set1(input logic [15:0] m, input logic [7:0] e, input logic s);
    req1_mant_i = m; req1_exp_i = e; req1_sign_i = s;
  endtask
  initial begin
    step(2);
    rst = 0;
    chk("rst_valid", 32'(out_valid_o), 0);
    chk("rst_mant", 32'(out_mant_o), 0);
    chk("rst_exp", 32'(out_exp_o), 0);
    set0(16'h0100, 8'd20, 1'b1);
    req_valid_i = 2'b01;
    step(1);
    req_valid_i = 2'b00;
    step(1);
    chk("first_valid", 32'(out_valid_o), 1);
    chk("first_mant", 32'(out_mant_o), 32'h8000);
    chk("first_exp", 32'(out_exp_o), 13);
    step(2);
    rst = 1;
    step(1);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      set0(16'h0010 << i, 8'(40 + i), 1'b0);
      set1(16'h0003 << i, 8'(60 + i), 1'b1);
      req_valid_i = 2'b11;
      step(1);
    end
    req_valid_i = 2'b00;
    step(3);
    req_valid_i = 2'b01;
    set0(16'h0000, 8'd50, 1'b0); step(1);
    set0(16'h0001, 8'd15, 1'b1); step(1);
    set0(16'h0001, 8'd16, 1'b0); step(1);
    set0(16'h8123, 8'd127, 1'b1); step(1);
    req_valid_i = 2'b00;
    step(3);
    out_ready_i = 0;
    req_valid_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      set1(16'h0040 + 16'(i), 8'(30 + i), i[0]);
      step(1);
    end
    out_ready_i = 1;
    step(6);
    req_valid_i = 2'b00;
    step(2);
    out_ready_i = 0;
    req_valid_i = 2'b11;
    step(3);
    rst = 1;
    step(1);
    rst = 0;
    out_ready_i = 1;
    chk("rst_flush_valid", 32'(out_valid_o), 0);
    chk("rst_grant0", 32'(req_ready_o), 32'h1);
    step(3);
    for (int i = 0; i < 3000; i++) begin
      req_valid_i = 2'($urandom);
      set0(16'($urandom >> $urandom_range(0, 16)), 8'($urandom), 1'($urandom));
      set1(16'($urandom >> $urandom_range(0, 16)), 8'($urandom), 1'($urandom));
      out_ready_i = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
      step(1);
    end
    rst = 0;
    req_valid_i = 2'b00;
    out_ready_i = 1;
    step(4);
    chk("drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
